// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS front end: reset/bubble defaults,
// instruction ROM addressing and the next-PC select encoding.
package mips_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

   // Instruction ROM is word addressed by addr[9:2].
   localparam int unsigned ROM_IDX_LSB = 2;
   localparam int unsigned ROM_IDX_MSB = 9;
   localparam int unsigned ROM_DEPTH   = 1 << (ROM_IDX_MSB - ROM_IDX_LSB + 1);

   typedef enum logic [1:0] {
      SEL_SEQ,
      SEL_JUMP,
      SEL_JR,
      SEL_BRANCH
   } npc_sel_e;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/next_pc_mux.sv
// Next-PC priority select (branch > jr > jump > sequential) with word alignment.
// Also reports whether the PC register should load and whether a redirect happens.
module next_pc_mux
   import mips_pkg::*;
(
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jr,
   input  logic [31:0] jr_target,
   input  logic        jump,
   input  logic [25:0] jump_index,
   input  logic [31:0] pc_plus4,
   input  logic [3:0]  id_pc_hi,
   output logic [31:0] next_pc,
   output logic        load_pc,
   output logic        redirect
);

   npc_sel_e    sel;
   logic [31:0] raw_pc;

   // ID-stage redirects are ignored under stall; ID will re-present them.
   always_comb begin
      sel = SEL_SEQ;
      if (branch_taken) begin
         sel = SEL_BRANCH;
      end else if (!stall && jr) begin
         sel = SEL_JR;
      end else if (!stall && jump) begin
         sel = SEL_JUMP;
      end
   end

   always_comb begin
      raw_pc = pc_plus4;
      unique case (sel)
         SEL_BRANCH: raw_pc = branch_target;
         SEL_JR:     raw_pc = jr_target;
         SEL_JUMP:   raw_pc = {id_pc_hi, jump_index, 2'b00};
         default:    raw_pc = pc_plus4;
      endcase
   end

   assign next_pc  = align_word(raw_pc);
   assign redirect = (sel != SEL_SEQ);
   assign load_pc  = branch_taken || !stall;

endmodule

// File: rtl/instruction_fetch_stage.sv
// IF stage: PC register, instruction ROM addressing, IF/ID pipeline register
// with stall/flush/redirect bubble handling, and an accepted-fetch counter.
module instruction_fetch_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [25:0] jump_index,
   input  logic        jr,
   input  logic [31:0] jr_target,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   output logic [31:0] pc,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc_plus4,
   output logic        if_id_valid,
   output logic [31:0] fetch_count
);

   logic [31:0] pc_q;
   logic [31:0] pc_plus4;
   logic [31:0] next_pc;
   logic        load_pc;
   logic        redirect;

   logic [31:0] if_id_instr_q;
   logic [31:0] if_id_pc_plus4_q;
   logic        if_id_valid_q;
   logic [31:0] fetch_count_q;

   assign pc_plus4 = pc_q + 32'd4;

   next_pc_mux u_next_pc_mux (
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jr            (jr),
      .jr_target     (jr_target),
      .jump          (jump),
      .jump_index    (jump_index),
      .pc_plus4      (pc_plus4),
      .id_pc_hi      (if_id_pc_plus4_q[31:28]),
      .next_pc       (next_pc),
      .load_pc       (load_pc),
      .redirect      (redirect)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q <= RESET_PC;
      end else if (load_pc) begin
         pc_q <= next_pc;
      end
   end

   // A redirect squashes the wrong-path word; flush wins over stall.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         if_id_instr_q    <= NOP_INSTR;
         if_id_pc_plus4_q <= '0;
         if_id_valid_q    <= 1'b0;
         fetch_count_q    <= '0;
      end else if (redirect || flush) begin
         if_id_instr_q    <= NOP_INSTR;
         if_id_pc_plus4_q <= '0;
         if_id_valid_q    <= 1'b0;
      end else if (!stall) begin
         if_id_instr_q    <= imem_instr;
         if_id_pc_plus4_q <= pc_plus4;
         if_id_valid_q    <= 1'b1;
         fetch_count_q    <= fetch_count_q + 32'd1;
      end
   end

   assign imem_addr      = pc_q;
   assign pc             = pc_q;
   assign if_id_instr    = if_id_instr_q;
   assign if_id_pc_plus4 = if_id_pc_plus4_q;
   assign if_id_valid    = if_id_valid_q;
   assign fetch_count    = fetch_count_q;

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
IF stage of the pipelined MIPS core. It owns the PC register, drives the byte address to the combinational instruction ROM, and selects the next PC from sequential, jump, jump-register and branch redirects. It also registers the returned word into the IF/ID pipeline register, with stall hold, flush bubble and a fetch counter. Downstream consumer is the ID stage.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, word inserted into IF/ID on bubble/flush

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
stall  in  1  hazard-unit hold: freeze PC and IF/ID
flush  in  1  replace IF/ID contents with bubble next edge
branch_taken  in  1  EX-stage branch resolved taken
branch_target  in  32  EX-stage branch target (byte address)
jump  in  1  ID-stage j/jal decoded
jump_index  in  26  instr[25:0] of j/jal in ID
jr  in  1  ID-stage jr/jalr decoded
jr_target  in  32  forwarded rs value
imem_addr  out  32  byte address to instruction ROM (= pc)
imem_instr  in  32  ROM data, combinational from imem_addr
pc  out  32  current PC
if_id_instr  out  32  registered instruction to ID
if_id_pc_plus4  out  32  registered PC+4 of that instruction
if_id_valid  out  1  1 = real instruction, 0 = bubble
fetch_count  out  32  number of instructions accepted into IF/ID

Behaviour:
- Reset (async, any time incl. mid-redirect): pc=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc_plus4=0, if_id_valid=0, fetch_count=0. First real fetch is RESET_PC on the first edge after deassertion; if_id_valid=1 one cycle later.
- imem_addr=pc combinationally; fetch latency is 1 cycle (ROM read same cycle, IF/ID captured on edge).
- pc_plus4 = pc + 32'd4, mod 2^32 (0xFFFF_FFFC wraps to 0).
- Next-PC priority, highest first: branch_taken -> branch_target; jr -> jr_target; jump -> {pc_plus4_of_ID[31:28], jump_index, 2'b00}, using if_id_pc_plus4; else pc_plus4.
- All loaded PC values are forced to bits[1:0]=2'b00. Misaligned target low bits are discarded and no fault is raised.
- stall=1 with no redirect: pc and IF/ID hold, fetch_count holds.
- Redirect over stall: branch_taken overrides stall because EX is older than the stalled instruction. pc loads the target, IF/ID becomes a bubble, and fetch_count does not increment. jr/jump while stall=1 are ignored, since ID is held and will re-present them.
- Redirect IF/ID effect: branch_taken, jr or jump make the next IF/ID a bubble (the wrong-path fetch is squashed) and pc loads the target.
- flush=1: IF/ID gets a bubble (NOP_INSTR, valid=0), pc advances normally unless stall holds it. flush wins over stall for IF/ID contents.
- Normal cycle: if_id_instr<=imem_instr, if_id_pc_plus4<=pc_plus4, if_id_valid<=1, fetch_count<=fetch_count+1 (wraps at 2^32).
- No internal FSM beyond the PC/valid registers. Behaviour is fully determined by the priority above.

Decomposition:
- Shared package (mips_pkg): RESET_PC default, NOP_INSTR, ROM address slice constants (word index = addr[9:2]), and the next-PC select encoding (SEL_SEQ, SEL_JUMP, SEL_JR, SEL_BRANCH).
- One sub-module: next_pc_mux, a combinational priority select plus alignment. Put the PC, IF/ID and counter registers in the top.

Test Plan:
- Reset deassert with ROM word0=32'h24100000, word1=32'h3c014000 -> imem_addr 0x0, 0x4 on successive cycles; if_id_instr 24100000 then 3c014000; valid 0 then 1; fetch_count 1, 2.
- jump=1, jump_index=26'h0000007, if_id_pc_plus4=0x10 -> next pc=0x1C, following IF/ID is a bubble (valid=0, instr=NOP_INSTR).
- branch_taken=1, branch_target=0x103 with stall=1 -> pc=0x100 next cycle, IF/ID bubble, fetch_count unchanged.
- stall=1 for 3 cycles at pc=0x20 -> pc, if_id_instr and fetch_count constant; jump asserted during stall -> ignored.
- jr=1, jr_target=0x40 together with jump=1 -> pc=0x40 (jr wins). Same cycle branch_taken=1, target 0x80 -> pc=0x80.
- Reset asserted mid-cycle after a branch load to pc=0x80 -> outputs return to reset values immediately without a clock edge. pc=0xFFFF_FFFC with sequential fetch -> pc wraps to 0x0.
